// File: rtl/trng_pkg.sv
// trng_pkg: shared state encodings, default parameter values and a small
// saturating-counter helper for the TRNG conditioner.
package trng_pkg;

    // Von Neumann pair tracker: waiting for the first or the second sample of a pair
    typedef enum logic {
        PAIR_FIRST  = 1'b0,
        PAIR_SECOND = 1'b1
    } pair_state_e;

    // Output word holder: no word pending, or a word waiting for the consumer
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    localparam int TRNG_OUT_WIDTH_DEF  = 32'sd8;
    localparam int TRNG_RCT_CUTOFF_DEF = 32'sd32;

    // Repetition counter increment that sticks at its maximum value
    function automatic logic [7:0] rct_sat_inc(input logic [7:0] cnt);
        logic [7:0] nxt;
        if (cnt == 8'hFF) begin
            nxt = 8'hFF;
        end else begin
            nxt = cnt + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: brings the asynchronous raw latch output into the clk domain
// through two flops and runs the Von Neumann pair FSM. For every sampled pair
// whose bits differ, bit_vld pulses for the sampling cycle with bit_val = the
// first bit of the pair. smp_bit is the synchronized sample (for health tests).
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic raw_bit,
    input  logic sample_en,
    output logic smp_bit,
    output logic bit_vld,
    output logic bit_val
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        stored_q, stored_d;
    pair_state_e pair_state_q, pair_state_d;
    logic        bit_vld_s;

    // Next-state for the synchronizer and the pair FSM, plus the debiased-bit strobe
    always_comb begin
        sync1_d      = raw_bit;
        sync2_d      = sync1_q;
        stored_d     = stored_q;
        pair_state_d = pair_state_q;
        bit_vld_s    = 1'b0;
        if (sample_en) begin
            case (pair_state_q)
                PAIR_FIRST: begin
                    stored_d     = sync2_q;
                    pair_state_d = PAIR_SECOND;
                end
                PAIR_SECOND: begin
                    pair_state_d = PAIR_FIRST;
                    bit_vld_s    = (stored_q != sync2_q);
                end
                default: begin
                    pair_state_d = PAIR_FIRST;
                end
            endcase
        end else begin
            pair_state_d = pair_state_q;
        end
    end

    // Synchronizer and pair FSM registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stored_q     <= 1'b0;
            pair_state_q <= PAIR_FIRST;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stored_q     <= stored_d;
            pair_state_q <= pair_state_d;
        end
    end

    assign smp_bit = sync2_q;
    assign bit_vld = bit_vld_s;
    assign bit_val = stored_q;

endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: packs Von Neumann debiased bits (first bit -> MSB) into
// OUT_WIDTH-bit words with a valid/ready output. When a word is pending and
// the accumulator is one bit short, further bits are dropped and overflow
// latches. Optional macro TRNG_CONDITIONER_HEALTH_EN adds a repetition-count
// health test that latches health_fail and stops new words from loading.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int OUT_WIDTH  = TRNG_OUT_WIDTH_DEF,
    parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 raw_bit,
    input  logic                 sample_en,
    output logic [OUT_WIDTH-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overflow,
    output logic                 health_fail
);

    localparam int CNT_W = $clog2(OUT_WIDTH);

    logic                 smp_bit_s;
    logic                 bit_vld_s;
    logic                 bit_val_s;
    logic                 hold_s;

    logic [OUT_WIDTH-2:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    out_state_e           out_state_q, out_state_d;
    logic                 overflow_q, overflow_d;

    logic [OUT_WIDTH-1:0] word_s;
    logic                 full_s;
    logic                 last_bit_s;
    logic                 take_s;
    logic                 load_s;

    trng_vn_debias u_debias (
        .clk       (clk),
        .resetn    (resetn),
        .raw_bit   (raw_bit),
        .sample_en (sample_en),
        .smp_bit   (smp_bit_s),
        .bit_vld   (bit_vld_s),
        .bit_val   (bit_val_s)
    );

    // Accumulator, word load / drop decision and output FSM next state
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        out_state_d = out_state_q;
        overflow_d  = overflow_q;
        word_s      = {acc_q, bit_val_s};
        full_s      = (out_state_q == OUT_FULL);
        last_bit_s  = (cnt_q == CNT_W'(OUT_WIDTH - 1));
        take_s      = bit_vld_s && !hold_s;
        load_s      = 1'b0;
        if (take_s && last_bit_s) begin
            if (full_s && !ready) begin
                overflow_d = 1'b1;
            end else begin
                load_s = 1'b1;
                data_d = word_s;
                cnt_d  = '0;
            end
        end else if (take_s) begin
            acc_d = word_s[OUT_WIDTH-2:0];
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
        end
        case (out_state_q)
            OUT_EMPTY: begin
                if (load_s) begin
                    out_state_d = OUT_FULL;
                end else begin
                    out_state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (load_s) begin
                    out_state_d = OUT_FULL;
                end else if (ready) begin
                    out_state_d = OUT_EMPTY;
                end else begin
                    out_state_d = OUT_FULL;
                end
            end
            default: begin
                out_state_d = OUT_EMPTY;
            end
        endcase
    end

    // Accumulator, output word and output FSM registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            out_state_q <= OUT_EMPTY;
            overflow_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            out_state_q <= out_state_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef TRNG_CONDITIONER_HEALTH_EN
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       rep_last_q, rep_last_d;
    logic       health_fail_q, health_fail_d;

    // Repetition count over consecutive identical samples; trips at RCT_CUTOFF
    always_comb begin
        rep_cnt_d     = rep_cnt_q;
        rep_last_d    = rep_last_q;
        health_fail_d = health_fail_q;
        if (sample_en) begin
            if ((rep_cnt_q != 8'd0) && (smp_bit_s == rep_last_q)) begin
                rep_cnt_d = rct_sat_inc(rep_cnt_q);
            end else begin
                rep_cnt_d = 8'd1;
            end
            rep_last_d = smp_bit_s;
            if (rep_cnt_d >= 8'(RCT_CUTOFF)) begin
                health_fail_d = 1'b1;
            end else begin
                health_fail_d = health_fail_q;
            end
        end else begin
            rep_cnt_d = rep_cnt_q;
        end
    end

    // Health test registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rep_cnt_q     <= 8'd0;
            rep_last_q    <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            rep_cnt_q     <= rep_cnt_d;
            rep_last_q    <= rep_last_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign hold_s      = health_fail_q;
    assign health_fail = health_fail_q;
`else
    logic health_unused_s;

    assign health_unused_s = smp_bit_s;
    assign hold_s          = 1'b0;
    assign health_fail     = 1'b0;
`endif

    assign data     = data_q;
    assign valid    = (out_state_q == OUT_FULL);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed scenarios plus randomized samples, all checked
// every cycle against a behavioural model built from queues and counters.
module tb_trng_conditioner;

    localparam int W   = 8;
    localparam int RCT = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         raw_bit;
    logic         sample_en;
    logic         ready;
    logic [W-1:0] data;
    logic         valid;
    logic         overflow;
    logic         health_fail;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic         m_s1, m_s2;
    bit           m_pending;
    logic         m_stored;
    logic         m_bits[$];
    logic [W-1:0] m_data;
    logic         m_valid, m_ovf, m_hf;
    int           m_rep_cnt;
    logic         m_rep_last;
    bit           valid_seen;

    // free-running clock
    always #5 clk = ~clk;

    trng_conditioner #(.OUT_WIDTH(W), .RCT_CUTOFF(RCT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .raw_bit     (raw_bit),
        .sample_en   (sample_en),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0;
        m_pending = 1'b0; m_stored = 1'b0;
        m_bits.delete();
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_hf = 1'b0;
        m_rep_cnt = 0; m_rep_last = 1'b0;
    endtask

    // advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        logic         s;
        bit           emit, hs, loaded;
        logic [W-1:0] w;
        if (!resetn) begin
            model_reset();
            return;
        end
        s = m_s2; emit = 1'b0; loaded = 1'b0;
        hs = m_valid && ready;
        if (sample_en) begin
            if (!m_pending) begin
                m_stored = s; m_pending = 1'b1;
            end else begin
                m_pending = 1'b0;
                emit = (m_stored != s);
            end
        end
        if (emit && !m_hf) begin
            if (m_valid && !hs && m_bits.size() == W - 1) begin
                m_ovf = 1'b1;
            end else begin
                m_bits.push_back(m_stored);
                if (m_bits.size() == W) begin
                    w = '0;
                    foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
                    m_data = w; m_bits.delete();
                    m_valid = 1'b1; loaded = 1'b1;
                end
            end
        end
        if (hs && !loaded) m_valid = 1'b0;
`ifdef TRNG_CONDITIONER_HEALTH_EN
        if (sample_en) begin
            if (m_rep_cnt != 0 && s == m_rep_last) m_rep_cnt = (m_rep_cnt < 255) ? m_rep_cnt + 1 : 255;
            else m_rep_cnt = 1;
            m_rep_last = s;
            if (m_rep_cnt >= RCT) m_hf = 1'b1;
        end
`endif
        m_s2 = m_s1; m_s1 = raw_bit;
    endtask

    // one clock: model step, rising edge, then compare on the falling edge
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (valid) valid_seen = 1'b1;
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("data", 32'(data), 32'(m_data));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("health_fail", 32'(health_fail), 32'(m_hf));
    endtask

    // present b, let it cross the synchronizer, then strobe sample_en once
    task automatic sample(input logic b);
        raw_bit = b; sample_en = 1'b0;
        tick(); tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic pair(input logic a, input logic b);
        sample(a);
        sample(b);
    endtask

    task automatic do_reset();
        resetn = 1'b0; sample_en = 1'b0;
        #1;
        model_reset();
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_health", 32'(health_fail), 32'd0);
        tick(); tick();
        resetn = 1'b1;
    endtask

    initial begin
        logic a;
        int   run;
        resetn = 1'b0; raw_bit = 1'b0; sample_en = 1'b0; ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // S1: eight (0,1) pairs -> 0x00, valid one cycle after last sample
        ready = 1'b1;
        for (int i = 0; i < 8; i++) pair(1'b0, 1'b1);
        check_eq("s1_latency_valid", 32'(valid), 32'd1);
        check_eq("s1_data", 32'(data), 32'h00);
        tick();
        check_eq("s1_consumed", 32'(valid), 32'd0);

        // S2: (1,0),(0,1) alternating -> 0xAA
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pair(1'b1, 1'b0);
            pair(1'b0, 1'b1);
        end
        check_eq("s2_data", 32'(data), 32'hAA);
        check_eq("s2_valid", 32'(valid), 32'd1);

        // S3: equal pairs only, runs kept short -> no word, no health trip
        do_reset();
        valid_seen = 1'b0; a = 1'b0; run = 0;
        for (int i = 0; i < 64; i++) begin
            if (run >= 10 || $urandom_range(0, 3) == 0) begin
                a = ~a; run = 0;
            end
            run++;
            pair(a, a);
        end
        check_eq("s3_valid_seen", 32'(valid_seen), 32'd0);
        check_eq("s3_health", 32'(health_fail), 32'd0);

        // S4: backpressure, 24 (1,0) pairs with ready low
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            pair(1'b1, 1'b0);
            if (i == 14) check_eq("s4_ovf_before_drop", 32'(overflow), 32'd0);
        end
        check_eq("s4_data_held", 32'(data), 32'hFF);
        check_eq("s4_valid", 32'(valid), 32'd1);
        check_eq("s4_overflow", 32'(overflow), 32'd1);
        ready = 1'b1;
        pair(1'b0, 1'b1);
        check_eq("s4_next_word", 32'(data), 32'hFE);
        check_eq("s4_next_valid", 32'(valid), 32'd1);

        // S6: reset after five debiased bits; next word only from fresh bits
        for (int i = 0; i < 5; i++) pair(1'b1, 1'b0);
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) pair(1'b0, 1'b1);
        check_eq("s6_fresh_word", 32'(data), 32'h00);
        check_eq("s6_valid", 32'(valid), 32'd1);

        // S5: 32 consecutive raw ones
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sample(1'b1);
            if (i == 30) check_eq("s5_health_31", 32'(health_fail), 32'd0);
        end
        valid_seen = 1'b0;
        for (int i = 0; i < 8; i++) pair(1'b1, 1'b0);
`ifdef TRNG_CONDITIONER_HEALTH_EN
        check_eq("s5_health_32", 32'(health_fail), 32'd1);
        check_eq("s5_no_valid", 32'(valid_seen), 32'd0);
`else
        check_eq("s5_health_off", 32'(health_fail), 32'd0);
        check_eq("s5_word", 32'(data), 32'hFF);
`endif

        // randomized samples, ready and idle gaps
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ready = 1'($urandom_range(0, 1));
            sample(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
